// File: rtl/imm_pkg.sv
// imm_pkg: shared format codes, FSM states and opcodes for the immediate encoder.
package imm_pkg;
  typedef enum logic [2:0] {
    FMT_I  = 3'd0,
    FMT_S  = 3'd1,
    FMT_B  = 3'd2,
    FMT_U  = 3'd3,
    FMT_J  = 3'd4,
    FMT_LI = 3'd5
  } fmt_e;
  typedef enum logic [1:0] {
    S_EMPTY,
    S_WORD,
    S_LI_HI
  } state_e;
  localparam logic [6:0] OP_LUI     = 7'b0110111;
  localparam logic [6:0] OP_OPIMM   = 7'b0010011;
  localparam logic [6:0] OP_OPIMM32 = 7'b0011011;
endpackage

// File: rtl/imm_field_pack.sv
// imm_field_pack: range-check a 64-bit immediate and scatter it into an RV64I format.
module imm_field_pack
  import imm_pkg::*;
(
  input  logic [2:0]  fmt_i,
  input  logic [31:0] base_i,
  input  logic [63:0] imm_i,
  output logic [31:0] instr_o,
  output logic        err_o
);
  logic ok_11, ok_12, ok_20, ok_31;
  assign ok_11 = &imm_i[63:11] || ~|imm_i[63:11];
  assign ok_12 = &imm_i[63:12] || ~|imm_i[63:12];
  assign ok_20 = &imm_i[63:20] || ~|imm_i[63:20];
  assign ok_31 = &imm_i[63:31] || ~|imm_i[63:31];
  always_comb begin
    instr_o = base_i;
    err_o   = 1'b1;
    case (fmt_i)
      FMT_I: begin
        instr_o = {imm_i[11:0], base_i[19:0]};
        err_o   = !ok_11;
      end
      FMT_S: begin
        instr_o = {imm_i[11:5], base_i[24:12], imm_i[4:0], base_i[6:0]};
        err_o   = !ok_11;
      end
      FMT_B: begin
        instr_o = {imm_i[12], imm_i[10:5], base_i[24:12], imm_i[4:1], imm_i[11], base_i[6:0]};
        err_o   = !ok_12 || imm_i[0];
      end
      FMT_U: begin
        instr_o = {imm_i[31:12], base_i[11:0]};
        err_o   = !ok_31 || |imm_i[11:0];
      end
      FMT_J: begin
        instr_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], base_i[11:0]};
        err_o   = !ok_20 || imm_i[0];
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/imm_encoder.sv
// imm_encoder: encode immediates into instruction templates, expanding LI into LUI+ADDIW or ADDI.
module imm_encoder
  import imm_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_fmt,
  input  logic [31:0]     in_base,
  input  logic [XLEN-1:0] in_imm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic            out_err,
  output logic            out_last
);
  state_e      state_q;
  logic [31:0] instr_q, pend_q;
  logic        err_q, last_q;
  logic [31:0] single_instr, lui_instr, lo_instr, lo_base, instr_d;
  logic        single_err, lui_err, lo_err, li_bad, is_li, two_d, err_d;
  logic [19:0] li_hi;
  logic [4:0]  rd;
  logic        accept, fire;
  assign is_li   = in_fmt == FMT_LI;
  assign rd      = in_base[11:7];
  // LUI value is rounded up when lo is negative so that ADDIW's sign extension cancels out
  assign li_hi   = in_imm[31:12] + {19'd0, in_imm[11]};
  assign lo_base = li_hi != 20'd0 ? {12'd0, rd, 3'd0, rd, OP_OPIMM32} : {12'd0, 5'd0, 3'd0, rd, OP_OPIMM};
  imm_field_pack u_single (
    .fmt_i(in_fmt), .base_i(in_base), .imm_i(in_imm), .instr_o(single_instr), .err_o(single_err)
  );
  imm_field_pack u_lui (
    .fmt_i(FMT_U), .base_i({20'd0, rd, OP_LUI}), .imm_i({{32{li_hi[19]}}, li_hi, 12'd0}),
    .instr_o(lui_instr), .err_o(lui_err)
  );
  imm_field_pack u_lo (
    .fmt_i(FMT_I), .base_i(lo_base), .imm_i({{52{in_imm[11]}}, in_imm[11:0]}),
    .instr_o(lo_instr), .err_o(lo_err)
  );
  assign li_bad  = !(&in_imm[63:31] || ~|in_imm[63:31]) || lui_err || lo_err;
  assign two_d   = is_li && !li_bad && li_hi != 20'd0;
  assign err_d   = is_li ? li_bad : single_err;
  assign instr_d = err_d ? in_base : is_li ? (two_d ? lui_instr : lo_instr) : single_instr;
  assign in_ready  = state_q == S_EMPTY || (state_q == S_WORD && out_ready);
  assign out_valid = state_q != S_EMPTY;
  assign accept    = in_valid && in_ready;
  assign fire      = out_valid && out_ready;
  assign out_instr = instr_q;
  assign out_err   = err_q;
  assign out_last  = last_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
      instr_q <= '0;
      pend_q  <= '0;
      err_q   <= 1'b0;
      last_q  <= 1'b0;
    end else if (accept) begin
      state_q <= two_d ? S_LI_HI : S_WORD;
      instr_q <= instr_d;
      pend_q  <= lo_instr;
      err_q   <= err_d;
      last_q  <= !two_d;
    end else if (fire) begin
      state_q <= state_q == S_LI_HI ? S_WORD : S_EMPTY;
      if (state_q == S_LI_HI) begin
        instr_q <= pend_q;
        err_q   <= 1'b0;
        last_q  <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_imm_encoder.sv
// tb_imm_encoder: scoreboard-driven bench for imm_encoder; expected words queued at drive time.
module tb_imm_encoder;
  typedef struct packed {
    logic [31:0] instr;
    logic        err;
    logic        last;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_fmt = 3'd0;
  logic [31:0] in_base = 32'd0;
  logic [63:0] in_imm = 64'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic        out_err;
  logic        out_last;
  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];

  imm_encoder #(.XLEN(64)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_base(in_base), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_err(out_err), .out_last(out_last)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word: got instr=%h err=%b last=%b, required no output", out_instr, out_err, out_last);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({out_instr, out_err, out_last} !== {e.instr, e.err, e.last}) begin
          errors++;
          $display("FAIL word: got instr=%h err=%b last=%b, required instr=%h err=%b last=%b",
                   out_instr, out_err, out_last, e.instr, e.err, e.last);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [2:0] f, input logic [31:0] b, input logic [63:0] imm, output int stalls);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_fmt   = f;
    in_base  = b;
    in_imm   = imm;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    stalls = n;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d words still expected, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, out_instr, out_err, out_last, in_ready} !== {1'b0, 32'd0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset: got valid=%b instr=%h err=%b last=%b ready=%b, required 0 00000000 0 0 1",
               out_valid, out_instr, out_err, out_last, in_ready);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    int s;
    out_ready = 1'b1;
    sb.push_back('{32'hFFF00093, 1'b0, 1'b1});
    send(3'd0, 32'h00000093, -64'sd1, s);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL latency: out_valid=%b one cycle after accept, required 1", out_valid);
    end
    wait_drain();
    sb.push_back('{32'hFE000EE3, 1'b0, 1'b1});
    send(3'd2, 32'h00000063, -64'sd4, s);
    sb.push_back('{32'h00000063, 1'b1, 1'b1});
    send(3'd2, 32'h00000063, 64'd4096, s);
    sb.push_back('{32'hFE003C23, 1'b0, 1'b1});
    send(3'd1, 32'h00003023, -64'sd8, s);
    sb.push_back('{32'hFFFFF06F, 1'b0, 1'b1});
    send(3'd4, 32'h0000006F, -64'sd2, s);
    sb.push_back('{32'h12345037, 1'b0, 1'b1});
    send(3'd3, 32'h00000037, 64'h12345000, s);
    sb.push_back('{32'h00000037, 1'b1, 1'b1});
    send(3'd3, 32'h00000037, 64'h12345001, s);
    sb.push_back('{32'h00000093, 1'b1, 1'b1});
    send(3'd0, 32'h00000093, 64'd2048, s);
    sb.push_back('{32'h00000013, 1'b1, 1'b1});
    send(3'd6, 32'h00000013, 64'd0, s);
    wait_drain();
  endtask

  task automatic test_li();
    int s;
    out_ready = 1'b1;
    sb.push_back('{32'h123462B7, 1'b0, 1'b0});
    sb.push_back('{32'hFFF2829B, 1'b0, 1'b1});
    send(3'd5, 32'h00000280, 64'h12345FFF, s);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL li_hi_ready: in_ready=%b while LUI held, required 0", in_ready);
    end
    wait_drain();
    sb.push_back('{32'h7FF00293, 1'b0, 1'b1});
    send(3'd5, 32'h00000280, 64'h7FF, s);
    sb.push_back('{32'h00000280, 1'b1, 1'b1});
    send(3'd5, 32'h00000280, 64'h1_0000_0000, s);
    sb.push_back('{32'h800002B7, 1'b0, 1'b0});
    sb.push_back('{32'hFFF2829B, 1'b0, 1'b1});
    send(3'd5, 32'h00000280, 64'h7FFFFFFF, s);
    sb.push_back('{32'h000052B7, 1'b0, 1'b0});
    sb.push_back('{32'h0002829B, 1'b0, 1'b1});
    send(3'd5, 32'hFFFFF2FF, 64'h5000, s);
    wait_drain();
  endtask

  task automatic test_backpressure();
    int s;
    out_ready = 1'b0;
    sb.push_back('{32'h00500093, 1'b0, 1'b1});
    send(3'd0, 32'h00000093, 64'd5, s);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, out_instr, out_err, in_ready} !== {1'b1, 32'h00500093, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL hold[%0d]: got valid=%b instr=%h err=%b ready=%b, required 1 00500093 0 0",
                 i, out_valid, out_instr, out_err, in_ready);
      end
    end
    out_ready = 1'b1;
    wait_drain();
  endtask

  task automatic test_back_to_back();
    int s, total;
    logic [63:0] imm;
    logic [31:0] base;
    total = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      imm  = 64'($signed(int'($urandom_range(4095)) - 2048));
      base = 32'h00000013 | (32'(i + 1) << 7);
      sb.push_back('{{imm[11:0], base[19:0]}, 1'b0, 1'b1});
      send(3'd0, base, imm, s);
      total += s;
    end
    checks++;
    if (total != 0) begin
      errors++;
      $display("FAIL throughput: %0d stall cycles over 8 requests, required 0", total);
    end
    wait_drain();
  endtask

  task automatic test_reset_li_hi();
    int s;
    out_ready = 1'b0;
    send(3'd5, 32'h00000280, 64'h12345FFF, s);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL reset_li_hi: got valid=%b ready=%b, required valid=0 ready=1", out_valid, in_ready);
    end
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_li_hi_idle: out_valid=%b, required 0", out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_li();
    test_backpressure();
    test_back_to_back();
    test_reset_li_hi();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
